tdm_demux_4: RTL

Receive-side counterpart of the 4:1 select mux. Takes a time-division-multiplexed sample stream, one slot per valid cycle with slot 0 flagged by frame_sync, and distributes the slots into four channel fields. Delivers each complete frame as a registered parallel word with a one-cycle strobe. Tracks frame alignment with a HUNT/LOCKED state machine and flags sync errors.

---
 rtl/tdm_demux_4.sv | 110 +++++++++++
 1 files changed

// File: rtl/tdm_demux_4.sv
// Receive-side TDM demultiplexer: collects four slots per frame (slot 0 marked by
// frame_sync) into a parallel word, with HUNT/LOCKED alignment tracking.
module tdm_demux_4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic [1:0]         slot,
  output logic               locked,
  output logic               sync_err
);

  // Handshake: din/frame_sync are consumed on any rising edge where din_valid=1;
  // there is no backpressure. frame_valid and sync_err are single-cycle pulses.

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   sbuf_q [3];
  logic [WIDTH-1:0]   sbuf_d [3];
  logic [4*WIDTH-1:0] dout_q, dout_d;
  logic               frame_valid_q, frame_valid_d;
  logic               sync_err_q, sync_err_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sbuf_d        = sbuf_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            sbuf_d[0] = din;
            slot_d    = 2'd1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync at a nonzero slot restarts the frame from this sample.
            sbuf_d[0]  = din;
            slot_d     = 2'd1;
            sync_err_d = (slot_q != 2'd0);
          end else begin
            case (slot_q)
              2'd0: begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
                slot_d     = 2'd0;
              end
              2'd1: begin
                sbuf_d[1] = din;
                slot_d    = 2'd2;
              end
              2'd2: begin
                sbuf_d[2] = din;
                slot_d    = 2'd3;
              end
              default: begin
                dout_d        = {din, sbuf_q[2], sbuf_q[1], sbuf_q[0]};
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      sbuf_q[0]     <= '0;
      sbuf_q[1]     <= '0;
      sbuf_q[2]     <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sbuf_q        <= sbuf_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule
